// File: rtl/ast_fifo_pkt.sv
// ============================================================================
// Module   : ast_fifo_pkt
// Purpose  : Avalon-ST FIFO with configurable depth, sink-side ready latency
//            (exact credit tracking), fill/almost-full status, stored-packet
//            counter and sticky overflow flag.
// Options  : define AST_FIFO_PKT_EN to store and return sop/eop/empty and
//            enable the packet counter; otherwise sideband is ignored.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ast_fifo_pkt #(
    parameter int DATABITS_PER_SYMBOL = 8,
    parameter int SYMBOLS_PER_BEAT    = 4,
    parameter int DEPTH               = 16,
    parameter int READY_LATENCY       = 0,
    parameter int ALMOST_FULL         = 12,
    parameter int EMPTY_W             = (SYMBOLS_PER_BEAT > 1) ? $clog2(SYMBOLS_PER_BEAT) : 1
) (
    input  logic                                            clk_i,
    input  logic                                            rst_i,
    input  logic [DATABITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] snk_data_i,
    input  logic                                            snk_valid_i,
    output logic                                            snk_ready_o,
    input  logic                                            snk_sop_i,
    input  logic                                            snk_eop_i,
    input  logic [EMPTY_W-1:0]                              snk_empty_i,
    output logic [DATABITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] src_data_o,
    output logic                                            src_valid_o,
    input  logic                                            src_ready_i,
    output logic                                            src_sop_o,
    output logic                                            src_eop_o,
    output logic [EMPTY_W-1:0]                              src_empty_o,
    output logic [$clog2(DEPTH):0]                          fill_level_o,
    output logic                                            almost_full_o,
    output logic [$clog2(DEPTH):0]                          pkt_cnt_o,
    output logic                                            overflow_o
);

    localparam int c_width = DATABITS_PER_SYMBOL * SYMBOLS_PER_BEAT;
    localparam int c_aw    = $clog2(DEPTH);
    localparam int c_cw    = c_aw + 1;
`ifdef AST_FIFO_PKT_EN
    localparam int c_entry_w = c_width + 2 + EMPTY_W;
`else
    localparam int c_entry_w = c_width;
`endif
    localparam logic [c_cw-1:0] c_ptr_one = c_cw'(1);

    logic [c_entry_w-1:0] r_mem [DEPTH];
    logic [c_cw-1:0]      r_wr_ptr;
    logic [c_cw-1:0]      r_rd_ptr;
    logic [c_cw-1:0]      r_fill;
    logic                 r_ready;
    logic                 r_afull;
    logic                 r_ovf;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_write;
    logic                 w_read;
    logic                 w_overflow;
    logic                 w_ready_next;
    logic [c_cw-1:0]      w_fill_next;
    logic [c_cw-1:0]      w_pending_next;
    logic [c_cw:0]        w_credit;
    logic [c_entry_w-1:0] w_wr_entry;
    logic [c_entry_w-1:0] w_head;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_full      = (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]) &&
                         (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]);
    assign w_read      = !w_empty && src_ready_i;
    assign w_overflow  = snk_valid_i && w_full && !w_write;
    assign w_fill_next = r_fill + c_cw'(w_write) - c_cw'(w_read);

    // Grant another credit only if every beat already promised still fits.
    assign w_credit     = {1'b0, w_fill_next} + {1'b0, w_pending_next};
    assign w_ready_next = (w_credit < (c_cw + 1)'(DEPTH));

    generate
        if (READY_LATENCY == 0) begin : g_rl_zero
            assign w_write        = snk_valid_i && r_ready;
            assign w_pending_next = '0;
        end else begin : g_rl_credit
            logic [READY_LATENCY-1:0] r_hist;
            logic [READY_LATENCY-1:0] w_hist_next;

            // Beats arrive without re-checking ready; a pop frees a slot in the same cycle.
            assign w_write = snk_valid_i && (!w_full || w_read);

            // Count grants issued within the latency window that may still land.
            always_comb begin
                w_hist_next    = r_hist << 1;
                w_hist_next[0] = r_ready;
                w_pending_next = '0;
                for (int i = 0; i < READY_LATENCY; i++) begin
                    w_pending_next = w_pending_next + c_cw'(w_hist_next[i]);
                end
            end

            // History of ready values presented to the source.
            always_ff @(posedge clk_i) begin
                if (!rst_i) begin
                    r_hist <= '0;
                end else begin
                    r_hist <= w_hist_next;
                end
            end
        end
    endgenerate

    // Pointer, occupancy, credit and status registers.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
            r_ready  <= 1'b0;
            r_afull  <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_read) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            r_fill  <= w_fill_next;
            r_ready <= w_ready_next;
            r_afull <= (w_fill_next >= c_cw'(ALMOST_FULL));
            if (w_overflow) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Storage array; contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk_i) begin
        if (w_write) begin
            r_mem[r_wr_ptr[c_aw-1:0]] <= w_wr_entry;
        end
    end

    assign w_head        = r_mem[r_rd_ptr[c_aw-1:0]];
    assign src_data_o    = w_head[c_width-1:0];
    assign src_valid_o   = !w_empty;
    assign snk_ready_o   = r_ready;
    assign fill_level_o  = r_fill;
    assign almost_full_o = r_afull;
    assign overflow_o    = r_ovf;

`ifdef AST_FIFO_PKT_EN
    logic [c_cw-1:0] r_pkt_cnt;

    assign w_wr_entry  = {snk_sop_i, snk_eop_i, snk_empty_i, snk_data_i};
    assign src_sop_o   = w_head[c_entry_w-1];
    assign src_eop_o   = w_head[c_entry_w-2];
    assign src_empty_o = w_head[c_width +: EMPTY_W];
    assign pkt_cnt_o   = r_pkt_cnt;

    // Complete packets stored: one per EOP beat written, minus EOP beats popped.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_pkt_cnt <= '0;
        end else begin
            r_pkt_cnt <= r_pkt_cnt + c_cw'(w_write && snk_eop_i) - c_cw'(w_read && src_eop_o);
        end
    end
`else
    logic w_unused_sideband;

    assign w_unused_sideband = &{1'b0, snk_sop_i, snk_eop_i, snk_empty_i};
    assign w_wr_entry        = snk_data_i;
    assign src_sop_o         = 1'b0;
    assign src_eop_o         = 1'b0;
    assign src_empty_o       = '0;
    assign pkt_cnt_o         = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ast_fifo_pkt.sv
// ============================================================================
// Module   : tb_ast_fifo_pkt
// Purpose  : Scoreboard bench for ast_fifo_pkt; one instance with ready
//            latency 0 and one with ready latency 2, driven side by side.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ast_fifo_pkt;

    localparam int DEPTH = 16;
    localparam int AF    = 12;

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [1:0]  emp;
        logic [31:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        snk_valid [2];
    logic        snk_sop   [2];
    logic        snk_eop   [2];
    logic [1:0]  snk_empty [2];
    logic [31:0] snk_data  [2];
    logic        src_ready [2];
    logic        d_snk_ready [2];
    logic        d_src_valid [2];
    logic        d_src_sop   [2];
    logic        d_src_eop   [2];
    logic [1:0]  d_src_empty [2];
    logic [31:0] d_src_data  [2];
    logic [4:0]  d_fill      [2];
    logic [4:0]  d_pkt       [2];
    logic        d_afull     [2];
    logic        d_ovf       [2];

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        ast_fifo_pkt #(
            .DEPTH         (DEPTH),
            .READY_LATENCY ((gi == 0) ? 0 : 2),
            .ALMOST_FULL   (AF)
        ) u_dut (
            .clk_i         (clk),
            .rst_i         (rst),
            .snk_data_i    (snk_data[gi]),
            .snk_valid_i   (snk_valid[gi]),
            .snk_ready_o   (d_snk_ready[gi]),
            .snk_sop_i     (snk_sop[gi]),
            .snk_eop_i     (snk_eop[gi]),
            .snk_empty_i   (snk_empty[gi]),
            .src_data_o    (d_src_data[gi]),
            .src_valid_o   (d_src_valid[gi]),
            .src_ready_i   (src_ready[gi]),
            .src_sop_o     (d_src_sop[gi]),
            .src_eop_o     (d_src_eop[gi]),
            .src_empty_o   (d_src_empty[gi]),
            .fill_level_o  (d_fill[gi]),
            .almost_full_o (d_afull[gi]),
            .pkt_cnt_o     (d_pkt[gi]),
            .overflow_o    (d_ovf[gi])
        );
    end

    task automatic chk(input int d, input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s[dut%0d] t=%0t: got %0h expected %0h", nm, d, $time, act, exp);
        end
    endtask

    // ---------------- scoreboard queues (expected stored beats) ----------------
    ent_t sb0[$];
    ent_t sb1[$];

    function automatic void sb_push(input int d, input ent_t e);
        if (d == 0) sb0.push_back(e); else sb1.push_back(e);
    endfunction
    function automatic void sb_clear(input int d);
        if (d == 0) sb0.delete(); else sb1.delete();
    endfunction
    function automatic int sb_size(input int d);
        return (d == 0) ? sb0.size() : sb1.size();
    endfunction
    function automatic ent_t sb_front(input int d);
        return (d == 0) ? sb0[0] : sb1[0];
    endfunction
    function automatic void sb_pop(input int d);
        if (d == 0) void'(sb0.pop_front()); else void'(sb1.pop_front());
    endfunction
    function automatic int sb_eops(input int d);
        int n = 0;
        if (d == 0) begin foreach (sb0[i]) n += sb0[i].eop ? 1 : 0; end
        else begin foreach (sb1[i]) n += sb1[i].eop ? 1 : 0; end
        return n;
    endfunction

    // ---------------- reference model (state after each edge) ----------------
    int m_fill [2];
    bit m_ready[2];
    bit m_ovf  [2];
    bit m_grant[2][2];   // grants issued in the last two cycles (index 0 newest)

    task automatic model_edge(input int d);
        bit   rd;
        bit   acc;
        int   pend;
        ent_t e;
        if (!rst) begin
            m_fill[d] = 0; m_ready[d] = 0; m_ovf[d] = 0;
            m_grant[d][0] = 0; m_grant[d][1] = 0;
            sb_clear(d);
            return;
        end
        rd = (m_fill[d] > 0) && src_ready[d];
        if (d == 0) acc = snk_valid[d] && m_ready[d];
        else        acc = snk_valid[d] && ((m_fill[d] < DEPTH) || rd);
        if (snk_valid[d] && !acc && (m_fill[d] == DEPTH)) m_ovf[d] = 1;
        if (acc) begin
            e.data = snk_data[d];
`ifdef AST_FIFO_PKT_EN
            e.sop = snk_sop[d]; e.eop = snk_eop[d]; e.emp = snk_empty[d];
`else
            e.sop = 1'b0; e.eop = 1'b0; e.emp = 2'd0;
`endif
            sb_push(d, e);
        end
        m_fill[d] = m_fill[d] + (acc ? 1 : 0) - (rd ? 1 : 0);
        if (d == 0) begin
            pend = 0;
        end else begin
            m_grant[d][1] = m_grant[d][0];
            m_grant[d][0] = m_ready[d];
            pend = (m_grant[d][0] ? 1 : 0) + (m_grant[d][1] ? 1 : 0);
        end
        m_ready[d] = (m_fill[d] + pend) < DEPTH;
    endtask

    initial forever begin
        @(posedge clk);
        for (int d = 0; d < 2; d++) model_edge(d);
    end

    // ---------------- monitor: status and head-of-queue checks ----------------
    task automatic monitor_cycle(input int d);
        ent_t h;
        chk(d, "snk_ready", d_snk_ready[d], m_ready[d]);
        chk(d, "fill", d_fill[d], m_fill[d]);
        chk(d, "almost_full", d_afull[d], m_fill[d] >= AF);
        chk(d, "overflow", d_ovf[d], m_ovf[d]);
        chk(d, "src_valid", d_src_valid[d], m_fill[d] > 0);
        chk(d, "pkt_cnt", d_pkt[d], sb_eops(d));
        if (d_src_valid[d]) begin
            if (sb_size(d) == 0) begin
                n_checks++; n_errs++;
                $display("FAIL head[dut%0d] t=%0t: got valid beat %0h expected no data", d, $time, d_src_data[d]);
            end else begin
                h = sb_front(d);
                chk(d, "data", d_src_data[d], h.data);
                chk(d, "sop", d_src_sop[d], h.sop);
                chk(d, "eop", d_src_eop[d], h.eop);
                chk(d, "empty", d_src_empty[d], h.emp);
                if (src_ready[d]) sb_pop(d);
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        for (int d = 0; d < 2; d++) monitor_cycle(d);
    end

    // ---------------- driver ----------------
    int          wr_left[2];
    int          wr_pct [2];
    int          rd_pct [2];
    bit          force0;
    bit          pkt_mode;
    logic [31:0] dcnt[2];
    bit          rh0, rh1, rh2;

    task automatic step();
        @(posedge clk);
        #1;
        rh2 = rh1; rh1 = rh0; rh0 = d_snk_ready[1];
        for (int d = 0; d < 2; d++) begin
            bit gate;
            bit v;
            gate = (d == 0) ? (force0 || d_snk_ready[0]) : rh2;
            v = rst && gate && (wr_left[d] > 0) && ($urandom_range(99) < wr_pct[d]);
            snk_valid[d] = v;
            if (v) begin
                wr_left[d]--;
                snk_data[d] = dcnt[d];
                if (pkt_mode) begin
                    snk_sop[d]   = (dcnt[d] % 3) == 0;
                    snk_eop[d]   = (dcnt[d] % 3) == 2;
                    snk_empty[d] = ((dcnt[d] % 3) == 2) ? 2'd2 : 2'd0;
                end else begin
                    snk_sop[d]   = 1'($urandom);
                    snk_eop[d]   = 1'($urandom);
                    snk_empty[d] = 2'($urandom);
                end
                dcnt[d]++;
            end else begin
                snk_data[d] = $urandom;
            end
            src_ready[d] = ($urandom_range(99) < rd_pct[d]);
        end
    endtask

    task automatic set_mode(input int wl, input int wp, input int rp);
        for (int d = 0; d < 2; d++) begin
            wr_left[d] = wl; wr_pct[d] = wp; rd_pct[d] = rp;
        end
    endtask

    initial begin
        rst = 1'b0; force0 = 0; pkt_mode = 0;
        rh0 = 0; rh1 = 0; rh2 = 0;
        for (int d = 0; d < 2; d++) begin
            snk_valid[d] = 0; snk_sop[d] = 0; snk_eop[d] = 0; snk_empty[d] = 0;
            snk_data[d] = 0; src_ready[d] = 0; dcnt[d] = 0;
        end
        set_mode(0, 100, 0);

        // reset state and first credit after release
        repeat (3) step();
        for (int d = 0; d < 2; d++) begin
            chk(d, "rst_fill", d_fill[d], 0);
            chk(d, "rst_ready", d_snk_ready[d], 0);
            chk(d, "rst_valid", d_src_valid[d], 0);
        end
        rst = 1'b1;
        step();
        for (int d = 0; d < 2; d++) chk(d, "ready_after_release", d_snk_ready[d], 1);

        // fill to capacity without reads, data 0x0..0xF
        dcnt[0] = 0; dcnt[1] = 0;
        set_mode(100, 100, 0);
        repeat (24) step();
        for (int d = 0; d < 2; d++) begin
            chk(d, "full_fill", d_fill[d], 16);
            chk(d, "full_ready", d_snk_ready[d], 0);
            chk(d, "full_afull", d_afull[d], 1);
            chk(d, "full_no_ovf", d_ovf[d], 0);
        end
        set_mode(0, 100, 100);
        repeat (20) step();
        for (int d = 0; d < 2; d++) chk(d, "drained_valid", d_src_valid[d], 0);

        // forced beat into a full latency-0 FIFO
        set_mode(100, 100, 0);
        repeat (20) step();
        force0 = 1;
        repeat (2) step();
        force0 = 0;
        set_mode(0, 100, 0);
        step();
        chk(0, "ovf_set", d_ovf[0], 1);
        repeat (3) step();
        chk(0, "ovf_sticky", d_ovf[0], 1);
        rst = 1'b0;
        step();
        chk(0, "ovf_cleared", d_ovf[0], 0);
        rst = 1'b1;
        step();

        // steady write+read at 8 entries across pointer wrap
        set_mode(8, 100, 0);
        repeat (12) step();
        set_mode(48, 100, 100);
        repeat (24) step();
        for (int d = 0; d < 2; d++) chk(d, "steady_fill", d_fill[d], 8);
        repeat (24) step();
        set_mode(0, 100, 100);
        repeat (20) step();

        // three-beat packet
        rst = 1'b0; step(); rst = 1'b1; step();
        dcnt[0] = 0; dcnt[1] = 0; pkt_mode = 1;
        set_mode(3, 100, 0);
        repeat (8) step();
`ifdef AST_FIFO_PKT_EN
        for (int d = 0; d < 2; d++) chk(d, "pkt_stored", d_pkt[d], 1);
`else
        for (int d = 0; d < 2; d++) chk(d, "pkt_stored", d_pkt[d], 0);
`endif
        set_mode(0, 100, 100);
        repeat (6) step();
        for (int d = 0; d < 2; d++) chk(d, "pkt_drained", d_pkt[d], 0);
        pkt_mode = 0;

        // randomized traffic
        set_mode(100000, 60, 50); repeat (300) step();
        set_mode(100000, 90, 30); repeat (150) step();
        set_mode(100000, 30, 90); repeat (150) step();
        set_mode(0, 100, 100);    repeat (24) step();
        for (int d = 0; d < 2; d++) chk(d, "random_drained", d_fill[d], 0);

        // reset with 5 entries stored
        set_mode(5, 100, 0);
        repeat (10) step();
        for (int d = 0; d < 2; d++) chk(d, "five_fill", d_fill[d], 5);
        rst = 1'b0;
        step();
        for (int d = 0; d < 2; d++) begin
            chk(d, "midrst_fill", d_fill[d], 0);
            chk(d, "midrst_valid", d_src_valid[d], 0);
            chk(d, "midrst_ready", d_snk_ready[d], 0);
        end
        rst = 1'b1;
        step();
        for (int d = 0; d < 2; d++) chk(d, "midrst_release", d_snk_ready[d], 1);
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within the time limit");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/ast_fifo_pkt.md
# ast_fifo_pkt

Parametrised Avalon-ST FIFO that stores data beats and, when enabled, packet sideband (start/end of packet, empty symbols). It sits between an Avalon-ST source and sink in the streaming datapath. It generalises the basic Avalon FIFO with configurable depth, a sink-side ready latency handled by exact credit tracking, fill/almost-full status, a stored-packet counter and a sticky overflow flag.

## Interface
Parameters:
- DATABITS_PER_SYMBOL, 8, bits per symbol
- SYMBOLS_PER_BEAT, 4, symbols per beat; WIDTH = DATABITS_PER_SYMBOL*SYMBOLS_PER_BEAT
- DEPTH, 16, entries; power of two, ≥ 4
- READY_LATENCY, 0, sink-side ready latency, 0..DEPTH/2
- ALMOST_FULL, 12, almost-full threshold in entries, 1..DEPTH
- EMPTY_W, max(1,$clog2(SYMBOLS_PER_BEAT)), width of the empty field (derived)

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  synchronous reset, active-low
- snk_data_i  in  WIDTH  write data
- snk_valid_i  in  1  write beat valid
- snk_ready_o  out  1  write credit, registered
- snk_sop_i / snk_eop_i  in  1 each  start / end of packet
- snk_empty_i  in  EMPTY_W  unused symbols in EOP beat
- src_data_o  out  WIDTH  read data, show-ahead
- src_valid_o  out  1  FIFO non-empty
- src_ready_i  in  1  read accept, ready latency 0
- src_sop_o / src_eop_o  out  1 each  stored sideband of head entry
- src_empty_o  out  EMPTY_W  stored empty of head entry
- fill_level_o  out  $clog2(DEPTH)+1  stored entries
- almost_full_o  out  1  fill_level_o ≥ ALMOST_FULL
- pkt_cnt_o  out  $clog2(DEPTH)+1  complete packets (stored EOP beats)
- overflow_o  out  1  sticky: beat arrived with FIFO full

## Operation
- Storage: register array DEPTH × (WIDTH + 2 + EMPTY_W); write/read pointers $clog2(DEPTH)+1 bits, MSB is the wrap bit; full = addresses equal and MSBs differ; empty = pointers equal.
- Write: beat taken whenever snk_valid_i = 1 and FIFO not full; snk_valid_i is not qualified by current snk_ready_o when READY_LATENCY > 0 (Avalon-ST latency-N rule).
- Credit: shift register hist[READY_LATENCY-1:0] records past snk_ready_o; pending = popcount(hist). Next snk_ready_o = (fill_next + pending_next) < DEPTH. READY_LATENCY = 0: snk_ready_o = !full, write = valid & ready.
- Overflow: valid beat while full is dropped, overflow_o set, held until reset. Never occurs with a compliant source.
- Read: src_valid_o = !empty; head entry presented combinationally from array; pop on src_valid_o & src_ready_i.
- fill_level_o: +1 write, −1 read, unchanged on simultaneous write+read.
- pkt_cnt_o: +1 on write with EOP, −1 on read with EOP, both → unchanged.
- Simultaneous read+write when full (READY_LATENCY > 0 only): accepted, fill unchanged. Write when empty: no bypass.

## Timing
- Reset (rst_i = 0 at edge): pointers, fill_level_o, pkt_cnt_o, hist, overflow_o, snk_ready_o, almost_full_o, src_valid_o cleared to 0; array contents don't-care. Mid-operation reset discards all contents.
- snk_ready_o rises the first edge after rst_i returns to 1.
- Write at edge t → src_valid_o and data visible after edge t (1-cycle latency); fill_level_o updated after same edge.
- Pop at edge t → next entry visible after edge t; src_valid_o falls if that emptied the FIFO.
- snk_ready_o, almost_full_o, fill_level_o, pkt_cnt_o, overflow_o all registered.

## Configuration
- AST_FIFO_PKT_EN defined: sop/eop/empty stored and returned, pkt_cnt_o counts.
- Undefined: sideband inputs ignored, not stored (array width WIDTH); src_sop_o, src_eop_o, src_empty_o, pkt_cnt_o tied 0. All other behaviour identical.

## Test plan
- Reset then DEPTH=16, RL=0, 16 writes 0x0..0xF no reads → snk_ready_o falls after 16th, fill 16, almost_full_o from 12th; drain → 0x0..0xF in order, src_valid_o low after last.
- RL=2, sink always sends when granted 2 cycles earlier, no reads → exactly 16 beats stored, overflow_o stays 0.
- RL=0, full FIFO, force snk_valid_i=1 → beat dropped, overflow_o=1 until rst_i=0.
- Continuous write+read each cycle from 8 entries → fill_level_o holds 8, data order preserved across pointer wrap (≥40 beats).
- AST_FIFO_PKT_EN: write 3-beat packet (sop beat 1, eop+empty=2 beat 3) → pkt_cnt_o 1 after beat 3, sideband returned exactly, pkt_cnt_o 0 after EOP pop.
- Reset asserted with 5 entries stored → next cycle fill 0, src_valid_o 0, snk_ready_o 0, then 1 after release.
